// File: rtl/decode_sequencer.sv
// decode_sequencer: circular byte queue presenting a MAX_INSN-byte window to the decoder and popping one instruction per cycle.
// Optional DECODE_ERR_HALT_EN: a final decode error halts the sequencer instead of dropping one byte.
module decode_sequencer #(
    parameter int BUF_BYTES   = 32,
    parameter int FETCH_BYTES = 8,
    parameter int MAX_INSN    = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [FETCH_BYTES*8-1:0] fetch_data,
    input  logic                     flush,
    input  logic [63:0]              flush_pc,
    output logic [MAX_INSN*8-1:0]    dec_window,
    input  logic [3:0]               dec_len,
    input  logic                     dec_err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MAX_INSN*8-1:0]    out_bytes,
    output logic [3:0]               out_len,
    output logic [63:0]              out_pc,
    output logic                     halted
);
    localparam int PW = $clog2(BUF_BYTES);
    localparam int CW = PW + 1;

    typedef enum logic {RUN, HALT} state_t;

    state_t                state_q;
    logic [7:0]            buf_q [BUF_BYTES];
    logic [PW-1:0]         head_q;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic [CW-1:0]         len_w;
    logic [63:0]           head_pc_q;
    logic                  out_valid_q;
    logic [MAX_INSN*8-1:0] out_bytes_q;
    logic [3:0]            out_len_q;
    logic [63:0]           out_pc_q;
    logic [MAX_INSN*8-1:0] pop_bytes;
    logic                  slot_free;
    logic                  accept;
    logic                  pop;
    logic                  fatal;
    logic                  drop;

    // Window bytes past the queued count read as zero; popped bytes past dec_len are zeroed too.
    always_comb begin
        dec_window = '0;
        pop_bytes  = '0;
        for (int i = 0; i < MAX_INSN; i++) begin
            dec_window[8*i +: 8] = (CW'(i) < count_q) ? buf_q[head_q + PW'(i)] : 8'h00;
            pop_bytes[8*i +: 8]  = (i < int'(dec_len)) ? dec_window[8*i +: 8] : 8'h00;
        end
    end

    assign len_w       = CW'(dec_len);
    assign tail        = head_q + count_q[PW-1:0];
    assign fetch_ready = (count_q <= CW'(BUF_BYTES - FETCH_BYTES)) && !flush && state_q == RUN;
    assign accept      = fetch_valid && fetch_ready;
    assign slot_free   = !out_valid_q || out_ready;
    assign pop         = state_q == RUN && slot_free && !dec_err && dec_len != 4'd0 && len_w <= count_q;
    assign fatal       = state_q == RUN && count_q >= CW'(MAX_INSN) && dec_err;

`ifdef DECODE_ERR_HALT_EN
    assign drop   = 1'b0;
    assign halted = state_q == HALT;
`else
    assign drop   = fatal;
    assign halted = 1'b0;
`endif

    assign count_d = count_q + (accept ? CW'(FETCH_BYTES) : '0) - (pop ? len_w : CW'(drop));

    assign out_valid = out_valid_q;
    assign out_bytes = out_bytes_q;
    assign out_len   = out_len_q;
    assign out_pc    = out_pc_q;

    always_ff @(posedge clk) begin
        if (accept)
            for (int j = 0; j < FETCH_BYTES; j++)
                buf_q[tail + PW'(j)] <= fetch_data[8*j +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            head_q      <= '0;
            count_q     <= '0;
            head_pc_q   <= '0;
            out_valid_q <= 1'b0;
            out_bytes_q <= '0;
            out_len_q   <= '0;
            out_pc_q    <= '0;
        end else if (flush) begin
            state_q     <= RUN;
            count_q     <= '0;
            head_pc_q   <= flush_pc;
            out_valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (pop) begin
                head_q      <= head_q + PW'(dec_len);
                head_pc_q   <= head_pc_q + 64'(dec_len);
                out_valid_q <= 1'b1;
                out_bytes_q <= pop_bytes;
                out_len_q   <= dec_len;
                out_pc_q    <= head_pc_q;
            end else begin
                if (out_ready)
                    out_valid_q <= 1'b0;
                if (drop) begin
                    head_q    <= head_q + PW'(1);
                    head_pc_q <= head_pc_q + 64'd1;
                end
            end
`ifdef DECODE_ERR_HALT_EN
            if (fatal)
                state_q <= HALT;
`endif
        end
    end
endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: directed scenarios plus random traffic checked every cycle against a byte-queue model.
module tb_decode_sequencer;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         fetch_valid = 1'b0;
    logic         fetch_ready;
    logic [63:0]  fetch_data = '0;
    logic         flush = 1'b0;
    logic [63:0]  flush_pc = '0;
    logic [119:0] dec_window;
    logic [3:0]   dec_len = '0;
    logic         dec_err = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [119:0] out_bytes;
    logic [3:0]   out_len;
    logic [63:0]  out_pc;
    logic         halted;

    int n_chk = 0;
    int n_pass = 0;

    byte unsigned mq[$];
    logic [63:0]  mpc;
    logic [63:0]  mop;
    logic [119:0] mob;
    logic [3:0]   mol;
    bit           mov;
    bit           mhalt;
    bit           rnd_dec = 1'b0;

    always #5 clk = ~clk;

    decode_sequencer dut (
        .clk(clk), .reset_n(reset_n), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_data(fetch_data), .flush(flush), .flush_pc(flush_pc), .dec_window(dec_window),
        .dec_len(dec_len), .dec_err(dec_err), .out_valid(out_valid), .out_ready(out_ready),
        .out_bytes(out_bytes), .out_len(out_len), .out_pc(out_pc), .halted(halted)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = '0; mop = '0; mob = '0; mol = '0; mov = 1'b0; mhalt = 1'b0;
    endtask

    function automatic logic [119:0] mwin();
        logic [119:0] w = '0;
        for (int i = 0; i < 15 && i < mq.size(); i++) w[8*i +: 8] = mq[i];
        return w;
    endfunction

    // Toy decoder: 0x48 is a 3-byte insn, otherwise low nibble gives length (0 means 1), 0xFF is undecodable.
    function automatic logic [3:0] ref_len(input logic [7:0] b);
        return b == 8'h48 ? 4'd3 : (b[3:0] == 4'd0 ? 4'd1 : b[3:0]);
    endfunction

    task automatic cyc(input bit fv, input logic [63:0] fd, input bit fl, input logic [63:0] fpc, input bit ordy);
        logic [119:0] w = mwin();
        int cnt = mq.size();
        bit rdy, pop, fatal;
        fetch_valid = fv; fetch_data = fd; flush = fl; flush_pc = fpc; out_ready = ordy;
        dec_len = ref_len(w[7:0]);
        dec_err = w[7:0] == 8'hFF;
        if (rnd_dec && $urandom_range(0, 9) == 0) begin
            dec_len = 4'($urandom_range(0, 15));
            dec_err = $urandom_range(0, 3) == 0;
        end
        #1;
        rdy = cnt <= 24 && !fl && !mhalt;
        chk("fetch_ready", fetch_ready, rdy);
        chk("dec_window", dec_window, w);
        chk("out_valid", out_valid, mov);
        chk("out_len", out_len, mol);
        chk("out_pc", out_pc, mop);
        chk("out_bytes", out_bytes, mob);
        chk("halted", halted, mhalt);
        if (fl) begin
            mq.delete(); mpc = fpc; mov = 1'b0; mhalt = 1'b0;
        end else begin
            pop = !mhalt && (!mov || ordy) && !dec_err && dec_len != 0 && dec_len <= cnt;
            fatal = !mhalt && cnt >= 15 && dec_err;
            if (pop) begin
                mov = 1'b1; mol = dec_len; mop = mpc; mob = '0;
                for (int i = 0; i < dec_len; i++) mob[8*i +: 8] = mq.pop_front();
                mpc += 64'(dec_len);
            end else if (ordy) mov = 1'b0;
            if (fatal) begin
`ifdef DECODE_ERR_HALT_EN
                mhalt = 1'b1;
`else
                void'(mq.pop_front());
                mpc += 64'd1;
`endif
            end
            if (fv && rdy) for (int i = 0; i < 8; i++) mq.push_back(fd[8*i +: 8]);
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        // Straight-line code: 48 89 e5 then five NOPs
        cyc(0, '0, 1, 64'h1000, 1);
        cyc(1, 64'h9090_9090_90e5_8948, 0, '0, 1);
        repeat (8) cyc(0, '0, 0, '0, 1);
        // 15-byte instruction across the buffer wrap, tail bytes arriving late
        cyc(0, '0, 1, 64'h1800, 1);
        cyc(1, 64'h9494_9494_9494_9494, 0, '0, 1);
        cyc(1, 64'h9494_9494_9494_9494, 0, '0, 1);
        cyc(1, 64'h0302_019F_0302_0194, 0, '0, 1);
        repeat (6) cyc(0, '0, 0, '0, 1);
        cyc(1, 64'h0b0a_0908_0706_0504, 0, '0, 1);
        repeat (3) cyc(0, '0, 0, '0, 1);
        cyc(1, 64'h1312_1110_0f0e_0d0c, 0, '0, 1);
        repeat (4) cyc(0, '0, 0, '0, 1);
        // Consumer stalled while the queue fills, then drains
        cyc(0, '0, 1, 64'h2000, 1);
        repeat (5) cyc(1, 64'h9191_9191_9191_9191, 0, '0, 0);
        repeat (36) cyc(0, '0, 0, '0, 1);
        // Flush colliding with a pop and a fetch beat
        cyc(0, '0, 1, 64'h3000, 1);
        cyc(1, 64'h9191_9191_9191_9191, 0, '0, 1);
        cyc(1, 64'h9191_9191_9191_9191, 0, '0, 1);
        cyc(1, 64'h9191_9191_9191_9191, 1, 64'h4000, 1);
        cyc(1, 64'h9292_9292_9292_9292, 0, '0, 1);
        repeat (6) cyc(0, '0, 0, '0, 1);
        // Undecodable head with 16 bytes queued
        cyc(0, '0, 1, 64'h5000, 1);
        cyc(1, 64'h0706_0504_0302_01FF, 0, '0, 1);
        cyc(1, 64'h0f0e_0d0c_0b0a_0908, 0, '0, 1);
        repeat (6) cyc(1, 64'h9191_9191_9191_9191, 0, '0, 1);
        cyc(0, '0, 1, 64'h5800, 1);
        repeat (3) cyc(0, '0, 0, '0, 1);
        // Asynchronous reset while an instruction is held
        cyc(0, '0, 1, 64'h6000, 1);
        repeat (3) cyc(1, 64'h9191_9191_9191_9191, 0, '0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_len", out_len, 4'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_bytes", out_bytes, 120'd0);
        chk("rst_window", dec_window, 120'd0);
        chk("rst_halted", halted, 1'b0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        // Random traffic
        rnd_dec = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            logic [63:0] d = {$urandom, $urandom};
            logic [63:0] p = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom};
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 63) == 0, p, $urandom_range(0, 3) != 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
